// File: rtl/register_file_if.sv
// Bus bundle for register_file: write/select/enable controls in, two tri-state read ports out.
interface register_file_if #(
    parameter int WIDTH     = 32,
    parameter int SEL_WIDTH = 8
);
    logic [WIDTH-1:0]     in;
    logic                 ld;
    logic [SEL_WIDTH-1:0] sel_a;
    logic [SEL_WIDTH-1:0] sel_b;
    logic                 oe_a;
    logic                 oe_b;
    wire  [WIDTH-1:0]     a;
    wire  [WIDTH-1:0]     b;

    modport master (
        output in, ld, sel_a, sel_b, oe_a, oe_b,
        input  a, b
    );

    modport slave (
        input  in, ld, sel_a, sel_b, oe_a, oe_b,
        output a, b
    );
endinterface

// File: rtl/register_file.sv
// Dual-read, single-write register file with tri-state read ports and async reset.
// Optional macro REGISTER_FILE_ZERO_REG_EN: register 0 is hard-wired to zero.
module register_file #(
    parameter int WIDTH     = 32,
    parameter int SEL_WIDTH = 8,
    parameter int NUM_REGS  = 16
) (
    input  logic            clk,
    input  logic            rst,
    register_file_if.slave  bus
);

`ifdef REGISTER_FILE_ZERO_REG_EN
    localparam int FIRST_WR = 1;
`else
    localparam int FIRST_WR = 0;
`endif

    logic [WIDTH-1:0]    r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] w_wr_en;
    logic [WIDTH-1:0]    w_rd_a;
    logic [WIDTH-1:0]    w_rd_b;

    if (NUM_REGS > 2**SEL_WIDTH) begin : g_bad_cfg
        $error("register_file: NUM_REGS exceeds the address space of SEL_WIDTH");
    end

    // Out-of-range write addresses match no register, so they fall away here.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign w_wr_en[gi] = (gi >= FIRST_WR) && bus.ld && (bus.sel_a == SEL_WIDTH'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_regs[gi] <= '0;
                end else if (w_wr_en[gi]) begin
                    r_regs[gi] <= bus.in;
                end
            end
        end
    endgenerate

    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.sel_a == SEL_WIDTH'(i)) begin
                w_rd_a = r_regs[i];
            end
            if (bus.sel_b == SEL_WIDTH'(i)) begin
                w_rd_b = r_regs[i];
            end
        end
    end

    assign bus.a = bus.oe_a ? w_rd_a : {WIDTH{1'bz}};
    assign bus.b = bus.oe_b ? w_rd_b : {WIDTH{1'bz}};

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: writes, dual reads, enables, range, async reset, zero register.
module tb_register_file;
    localparam int WIDTH     = 32;
    localparam int SEL_WIDTH = 8;
    localparam int NUM_REGS  = 16;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    register_file_if #(.WIDTH(WIDTH), .SEL_WIDTH(SEL_WIDTH)) bus ();

    register_file #(
        .WIDTH    (WIDTH),
        .SEL_WIDTH(SEL_WIDTH),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: got=%h", tag, got);
        end
    endtask

    task automatic write_reg(input logic [SEL_WIDTH-1:0] sel, input logic [WIDTH-1:0] data);
        @(negedge clk);
        bus.ld    = 1'b1;
        bus.sel_a = sel;
        bus.in    = data;
        @(negedge clk);
        bus.ld    = 1'b0;
    endtask

    task automatic read_both(input logic [SEL_WIDTH-1:0] sa, input logic [SEL_WIDTH-1:0] sb);
        bus.oe_a  = 1'b1;
        bus.oe_b  = 1'b1;
        bus.sel_a = sa;
        bus.sel_b = sb;
        #1;
    endtask

    logic [WIDTH-1:0] zero_reg_exp;
    logic [WIDTH-1:0] all_z;

    initial begin
        total = 0;
        bad   = 0;
        all_z = {WIDTH{1'bz}};
`ifdef REGISTER_FILE_ZERO_REG_EN
        zero_reg_exp = 32'd0;
`else
        zero_reg_exp = 32'd99;
`endif
        rst       = 1'b1;
        bus.in    = '0;
        bus.ld    = 1'b0;
        bus.sel_a = '0;
        bus.sel_b = '0;
        bus.oe_a  = 1'b0;
        bus.oe_b  = 1'b0;

        // Outputs during reset: enabled ports read zero
        @(negedge clk);
        read_both(8'd2, 8'd5);
        check("rst_a", bus.a, 32'd0);
        check("rst_b", bus.b, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Write 123 to reg 2 and read on both ports
        write_reg(8'd2, 32'd123);
        read_both(8'd2, 8'd2);
        check("r2_a", bus.a, 32'd123);
        check("r2_b", bus.b, 32'd123);

        write_reg(8'd3, 32'd321);
        read_both(8'd3, 8'd3);
        check("r3_a", bus.a, 32'd321);
        check("r3_b", bus.b, 32'd321);
        read_both(8'd2, 8'd2);
        check("r2_keep", bus.a, 32'd123);

        write_reg(8'd2, 32'd567);
        read_both(8'd2, 8'd2);
        check("r2_ow_a", bus.a, 32'd567);
        check("r2_ow_b", bus.b, 32'd567);
        read_both(8'd3, 8'd2);
        check("r3_keep", bus.a, 32'd321);

        // Both ports disabled -> high impedance
        bus.oe_a = 1'b0;
        bus.oe_b = 1'b0;
        #1;
        check("z_a", bus.a, all_z);
        check("z_b", bus.b, all_z);

        read_both(8'd16, 8'd255);
        check("oor_a", bus.a, 32'd0);
        check("oor_b", bus.b, 32'd0);

        // Out-of-range write must not disturb any register
        write_reg(8'd16, 32'hDEAD_BEEF);
        read_both(8'd2, 8'd3);
        check("oor_wr_r2", bus.a, 32'd567);
        check("oor_wr_r3", bus.b, 32'd321);
        read_both(8'd0, 8'd15);
        check("oor_wr_r0", bus.a, 32'd0);
        check("oor_wr_r15", bus.b, 32'd0);

        // Read during write: old value before the edge, new value after
        @(negedge clk);
        bus.oe_a  = 1'b1;
        bus.oe_b  = 1'b1;
        bus.sel_a = 8'd2;
        bus.sel_b = 8'd3;
        bus.in    = 32'd777;
        bus.ld    = 1'b1;
        #1;
        check("rdw_old", bus.a, 32'd567);
        @(posedge clk);
        #1;
        bus.ld = 1'b0;
        check("rdw_new", bus.a, 32'd777);
        check("rdw_b", bus.b, 32'd321);

        // Asynchronous reset mid-cycle with ld held high
        @(negedge clk);
        bus.sel_a = 8'd2;
        bus.sel_b = 8'd3;
        bus.in    = 32'd555;
        bus.ld    = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_a", bus.a, 32'd0);
        check("arst_b", bus.b, 32'd0);
        @(posedge clk);
        #1;
        check("arst_ld_blocked", bus.a, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_pre", bus.a, 32'd0);
        @(posedge clk);
        #1;
        bus.ld = 1'b0;
        check("post_rst_wr", bus.a, 32'd555);
        check("post_rst_r3", bus.b, 32'd0);

        // Register 0 behaviour depends on the zero-register build option
        write_reg(8'd0, 32'd99);
        read_both(8'd0, 8'd2);
        check("zero_reg", bus.a, zero_reg_exp);
        check("zero_reg_r2", bus.b, 32'd555);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
